// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad BCD entry block:
//                FSM state enum, frame-result encoding, key-code constants and
//                the row/column to key-code lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_res_e;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C,
    // row3 = * 0 # D.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;      4'h1: code = 4'h2;
            4'h2: code = 4'h3;      4'h3: code = KEY_A;
            4'h4: code = 4'h4;      4'h5: code = 4'h5;
            4'h6: code = 4'h6;      4'h7: code = KEY_B;
            4'h8: code = 4'h7;      4'h9: code = 4'h8;
            4'hA: code = 4'h9;      4'hB: code = KEY_C;
            4'hC: code = KEY_STAR;  4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;  default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_col_scanner.sv
// ============================================================================
//  Module      : keypad_col_scanner
//  Description : Drives the keypad columns one at a time, synchronises the
//                rows, and classifies each 4-slot frame as NONE, SINGLE(code)
//                or MULTI.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                row_n_i[3:0]    - asynchronous active-low rows
//                col_n_o[3:0]    - active-low one-hot column drive
//                frame_end_o     - strobe on the last cycle of the column-3 slot
//                result_o        - frame classification (valid with frame_end_o)
//                code_o          - key code for a SINGLE frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_n_i,
    output logic [3:0]       col_n_o,
    output logic             frame_end_o,
    output frame_res_e       result_o,
    output logic [3:0]       code_o
);

    localparam int            SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    col_q;
    logic [1:0]    acc_cnt_q;      // intersections seen this frame, saturating at 2
    logic [3:0]    acc_code_q;

    logic          w_slot_last;
    logic [3:0]    w_hits;
    logic [2:0]    w_pop;
    logic [2:0]    w_sum;
    logic [1:0]    w_cnt_new;
    logic [3:0]    w_code_new;

    assign w_slot_last = (slot_q == SLOT_LAST);
    assign w_hits      = w_slot_last ? ~sync2_q : 4'h0;
    assign w_sum       = {1'b0, acc_cnt_q} + w_pop;
    assign w_cnt_new   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

    // The current slot's sample is folded in combinationally so the frame
    // result on frame_end_o already includes column 3.
    always_comb begin
        w_pop      = 3'd0;
        w_code_new = acc_code_q;
        for (int r = 0; r < 4; r++) begin
            w_pop = w_pop + {2'b00, w_hits[r]};
        end
        if (acc_cnt_q == 2'd0 && w_pop == 3'd1) begin
            for (int r = 0; r < 4; r++) begin
                if (w_hits[r]) begin
                    w_code_new = key_lookup(2'(r), col_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            slot_q     <= '0;
            col_q      <= 2'd0;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else begin
            sync1_q <= row_n_i;
            sync2_q <= sync1_q;
            if (w_slot_last) begin
                slot_q <= '0;
                col_q  <= col_q + 2'd1;
                if (frame_end_o) begin
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= 4'h0;
                end else begin
                    acc_cnt_q  <= w_cnt_new;
                    acc_code_q <= w_code_new;
                end
            end else begin
                slot_q <= slot_q + SW'(1);
            end
        end
    end

    assign col_n_o     = ~(4'b0001 << col_q);
    assign frame_end_o = w_slot_last && (col_q == 2'd3);
    assign result_o    = (w_cnt_new == 2'd0) ? FR_NONE :
                         (w_cnt_new == 2'd1) ? FR_SINGLE : FR_MULTI;
    assign code_o      = w_code_new;

endmodule

`default_nettype wire

// File: rtl/keypad_bcd_entry_4digit.sv
// ============================================================================
//  Module      : keypad_bcd_entry_4digit
//  Description : 4x4 keypad front end: scans, debounces and decodes keys and
//                shifts digits into a 4-digit packed-BCD entry register.
//                '#' commits the entry to value, '*' clears the entry.
//                Build option KEYPAD_BACKSPACE_EN makes 'D' delete the newest
//                digit; otherwise 'D' only produces key_pulse.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                row_n[3:0]   - keypad rows, active-low, asynchronous
//                col_n[3:0]   - column drive, active-low one-hot
//                bcd[15:0]    - live entry, [15:12] oldest digit
//                value[15:0]  - last committed entry
//                value_valid  - one-cycle pulse when value updates
//                key_pulse    - one-cycle pulse per accepted key
//                key_code[3:0]- code of the last accepted key
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_bcd_entry_4digit
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] bcd,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        key_pulse,
    output logic [3:0]  key_code
);

    localparam int            CW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);

    logic        w_frame_end;
    frame_res_e  w_result;
    logic [3:0]  w_code;

    keypad_col_scanner #(
        .SCAN_DIV   (SCAN_DIV)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .row_n_i    (row_n),
        .col_n_o    (col_n),
        .frame_end_o(w_frame_end),
        .result_o   (w_result),
        .code_o     (w_code)
    );

    state_e        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          w_accept;

    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   value_q, value_d;
    logic          vv_q, vv_d;
    logic          kp_q, kp_d;
    logic [3:0]    kc_q, kc_d;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        w_accept = 1'b0;
        if (w_frame_end) begin
            case (state_q)
                IDLE: begin
                    if (w_result == FR_SINGLE) begin
                        cand_d = w_code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            w_accept = 1'b1;
                            rcnt_d   = '0;
                            state_d  = HELD;
                        end else begin
                            state_d  = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_result == FR_SINGLE && w_code == cand_q) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == DB_MAX) begin
                            w_accept = 1'b1;
                            rcnt_d   = '0;
                            state_d  = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // Release needs DEBOUNCE_SCANS consecutive empty frames;
                    // anything else, even a different key, keeps us held.
                    if (w_result != FR_NONE) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                        if (rcnt_d == DB_MAX) begin
                            rcnt_d  = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        value_d = value_q;
        vv_d    = 1'b0;
        kp_d    = 1'b0;
        kc_d    = kc_q;
        if (w_accept) begin
            kp_d = 1'b1;
            kc_d = cand_d;
            if (cand_d <= 4'd9) begin
                bcd_d = {bcd_q[11:0], cand_d};
            end else if (cand_d == KEY_STAR) begin
                bcd_d = 16'h0000;
            end else if (cand_d == KEY_HASH) begin
                value_d = bcd_q;
                vv_d    = 1'b1;
            end
`ifdef KEYPAD_BACKSPACE_EN
            else if (cand_d == KEY_D) begin
                bcd_d = {4'h0, bcd_q[15:4]};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 4'h0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            bcd_q   <= 16'h0000;
            value_q <= 16'h0000;
            vv_q    <= 1'b0;
            kp_q    <= 1'b0;
            kc_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            bcd_q   <= bcd_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            kp_q    <= kp_d;
            kc_q    <= kc_d;
        end
    end

    assign bcd         = bcd_q;
    assign value       = value_q;
    assign value_valid = vv_q;
    assign key_pulse   = kp_q;
    assign key_code    = kc_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_bcd_entry_4digit.sv
// ============================================================================
//  Module      : tb_keypad_bcd_entry_4digit
//  Description : Self-checking bench for keypad_bcd_entry_4digit with a
//                behavioural keypad, a decimal reference model and a
//                scoreboard checked on every key_pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_bcd_entry_4digit;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int FRAME          = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] bcd;
    logic [15:0] value;
    logic        value_valid;
    logic        key_pulse;
    logic [3:0]  key_code;

    keypad_bcd_entry_4digit #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .bcd        (bcd),
        .value      (value),
        .value_valid(value_valid),
        .key_pulse  (key_pulse),
        .key_code   (key_code)
    );

    always #5 clk = ~clk;

    // Keypad: pressed[row*4+col]; a row reads low when a pressed key sits on
    // a driven (low) column.
    logic [15:0] pressed = 16'h0;
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    function automatic int key_pos(input logic [3:0] k);
        int p = 0;
        for (int i = 0; i < 16; i++) if (layout[i] == k) p = i;
        return p;
    endfunction

    // Reference model: the entry held as a decimal integer 0..9999.
    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] bcd;
        logic [15:0] value;
        logic        vv;
    } exp_t;

    exp_t exp_q [$];
    int   m_entry = 0;
    int   m_value = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] to_bcd(input int n);
        return 16'((n / 1000) % 10 * 4096 + (n / 100) % 10 * 256 + (n / 10) % 10 * 16 + n % 10);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void expect_key(input logic [3:0] k);
        exp_t e;
        e.vv = 1'b0;
        if (k <= 4'd9) m_entry = (m_entry * 10 + int'(k)) % 10000;
        else if (k == 4'hE) m_entry = 0;
        else if (k == 4'hF) begin m_value = m_entry; e.vv = 1'b1; end
`ifdef KEYPAD_BACKSPACE_EN
        else if (k == 4'hD) m_entry = m_entry / 10;
`endif
        e.code  = k;
        e.bcd   = to_bcd(m_entry);
        e.value = to_bcd(m_value);
        exp_q.push_back(e);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (key_pulse) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pulse: key_code=%0h with no key expected", key_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("key_code", 32'(key_code), 32'(e.code));
                    chk("bcd", 32'(bcd), 32'(e.bcd));
                    chk("value", 32'(value), 32'(e.value));
                    chk("value_valid", 32'(value_valid), 32'(e.vv));
                end
            end else if (value_valid) begin
                n_cmp++; n_bad++;
                $display("FAIL stray_value_valid: got 1 without key_pulse, expected 0");
            end
        end
    end

    task automatic wait_frames(input int f);
        repeat (f * FRAME) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 4 * FRAME) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected key pulses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic press(input logic [3:0] k, input int frames, input bit accepted);
        if (accepted) expect_key(k);
        pressed = 16'h0;
        pressed[key_pos(k)] = 1'b1;
        wait_frames(frames);
        pressed = 16'h0;
        wait_frames(3);
    endtask

    task automatic press_two(input logic [3:0] a, input logic [3:0] b, input int frames);
        pressed = 16'h0;
        pressed[key_pos(a)] = 1'b1;
        pressed[key_pos(b)] = 1'b1;
        wait_frames(frames);
        pressed = 16'h0;
        wait_frames(3);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_entry = 0;
        m_value = 0;
        chk("rst_col_n", 32'(col_n), 32'h0E);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_key_pulse", 32'(key_pulse), 32'h0);
        chk("rst_value_valid", 32'(value_valid), 32'h0);
        chk("rst_key_code", 32'(key_code), 32'h0);
    endtask

    initial begin
        logic [3:0] ring [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        apply_reset();
        for (int i = 0; i < 4; i++) begin
            repeat (SCAN_DIV) @(negedge clk);
            chk("col_ring", 32'(col_n), 32'(ring[i]));
        end

        // Digit entry and commit
        for (int d = 1; d <= 5; d++) press(4'(d), 3, 1'b1);
        press(4'hF, 3, 1'b1);
        drain_check("entry_commit");
        chk("bcd_after_commit", 32'(bcd), 32'h2345);
        chk("value_after_commit", 32'(value), 32'h2345);

        // Bounce and multi-key: no accepts
        press(4'h7, 1, 1'b0);
        press_two(4'h1, 4'h5, 6);
        drain_check("bounce_multi");
        chk("bcd_after_bounce", 32'(bcd), 32'h2345);

        // Long hold gives one accept; then clear
        press(4'h8, 30, 1'b1);
        press(4'hE, 3, 1'b1);
        drain_check("hold_clear");
        chk("bcd_after_clear", 32'(bcd), 32'h0);
        chk("key_code_after_clear", 32'(key_code), 32'hE);

        // Reset while '9' is held
        expect_key(4'h9);
        pressed = 16'h0;
        pressed[key_pos(4'h9)] = 1'b1;
        wait_frames(3);
        drain_check("pre_reset_9");
        apply_reset();
        expect_key(4'h9);
        wait_frames(4);
        pressed = 16'h0;
        wait_frames(3);
        drain_check("post_reset_9");
        chk("bcd_after_reset_9", 32'(bcd), 32'h0009);

        // Backspace / plain 'D'
        press(4'hE, 3, 1'b1);
        for (int d = 1; d <= 4; d++) press(4'(d), 3, 1'b1);
        press(4'hD, 3, 1'b1);
        drain_check("key_d");
`ifdef KEYPAD_BACKSPACE_EN
        chk("bcd_after_d", 32'(bcd), 32'h0123);
`else
        chk("bcd_after_d", 32'(bcd), 32'h1234);
`endif
        chk("key_code_d", 32'(key_code), 32'hD);

        // Randomised key traffic
        for (int i = 0; i < 24; i++) begin
            int kind = int'($urandom_range(0, 9));
            logic [3:0] k = 4'($urandom_range(0, 15));
            logic [3:0] k2 = k + 4'($urandom_range(1, 15));
            if (kind == 0)      press(k, 1, 1'b0);
            else if (kind == 1) press_two(k, k2, 4);
            else                press(k, int'($urandom_range(3, 6)), 1'b1);
        end
        drain_check("random");
        chk("bcd_final", 32'(bcd), 32'(to_bcd(m_entry)));
        chk("value_final", 32'(value), 32'(to_bcd(m_value)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
